// File: rtl/ee354_bin2bcd_seq_if.sv
// ----------------------------------------------------------------------------
// ee354_bin2bcd_seq_if
//   Bundles the Start/Ack handshake, single-step enable, binary input and the
//   BCD result/status outputs of the sequential binary-to-BCD converter.
//
//   Signals:
//     SCEN    : single-clock enable (controller -> converter)
//     Start   : request conversion of Bin (controller -> converter)
//     Ack     : acknowledge result (controller -> converter)
//     Bin     : binary value to convert, WIDTH bits (controller -> converter)
//     Bcd     : packed BCD result, digit 0 in [3:0] (converter -> controller)
//     Cnt     : iterations completed in current conversion (converter -> controller)
//     q_I     : one-hot state flag, idle
//     q_Shift : one-hot state flag, converting
//     q_Done  : one-hot state flag, result valid
//
//   Modports:
//     master : the controller (GCD top / testbench) driving the converter
//     slave  : the converter itself
// ----------------------------------------------------------------------------
interface ee354_bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                  SCEN;
    logic                  Start;
    logic                  Ack;
    logic [WIDTH-1:0]      Bin;
    logic [4*DIGITS-1:0]   Bcd;
    logic [3:0]            Cnt;
    logic                  q_I;
    logic                  q_Shift;
    logic                  q_Done;

    modport master (
        output SCEN,
        output Start,
        output Ack,
        output Bin,
        input  Bcd,
        input  Cnt,
        input  q_I,
        input  q_Shift,
        input  q_Done
    );

    modport slave (
        input  SCEN,
        input  Start,
        input  Ack,
        input  Bin,
        output Bcd,
        output Cnt,
        output q_I,
        output q_Shift,
        output q_Done
    );

endinterface

// File: rtl/ee354_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// ee354_bin2bcd_seq
//   Sequential double-dabble binary-to-BCD converter. Sits downstream of the
//   GCD core and turns an 8-bit result into packed decimal digits for the SSD
//   mux. Uses the same Start/Ack handshake and SCEN single-step enable as the
//   GCD state machine, so it can share the debounced button pulses.
//
//   Ports:
//     Clk   : system clock
//     Reset : asynchronous, active-high reset
//     bus   : ee354_bin2bcd_seq_if.slave
//               SCEN, Start, Ack, Bin in; Bcd, Cnt, q_I, q_Shift, q_Done out
//
//   Conversion takes exactly WIDTH enabled cycles from the accepted Start to
//   q_Done. Bcd holds the last result until the next Start is accepted.
// ----------------------------------------------------------------------------
module ee354_bin2bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                        Clk,
    input  logic                        Reset,
    ee354_bin2bcd_seq_if.slave          bus
);

    localparam int unsigned BW = 4 * DIGITS;

    // One-hot encoding so the q_* flags come straight off state flops.
    typedef enum logic [2:0] {
        StIni   = 3'b001,
        StShift = 3'b010,
        StDone  = 3'b100
    } state_e;

    localparam logic [3:0] LastIter = 4'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    bcd_q;
    logic [3:0]       cnt_q;

    logic [BW-1:0]    bcd_adj;

    // Add-3 correction: any digit >= 5 would become >= 10 after the shift,
    // so pre-bias it by 3. Each digit is corrected independently (no carry).
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic [3:0]    digit;
        r = v;
        for (int d = 0; d < int'(DIGITS); d++) begin
            digit = v[4*d +: 4];
            if (digit >= 4'd5) begin
                digit = digit + 4'd3;
            end
            r[4*d +: 4] = digit;
        end
        return r;
    endfunction

    always_comb begin
        bcd_adj = add3_digits(bcd_q);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIni;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (bus.SCEN) begin
            unique case (state_q)
                StIni: begin
                    if (bus.Start) begin
                        bin_q   <= bus.Bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    // Shift {bcd, bin} left by one; the binary MSB enters BCD bit 0.
                    bcd_q <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                    bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LastIter) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Start is deliberately ignored here: a shared Start/Ack
                    // pulse must only return to idle.
                    if (bus.Ack) begin
                        state_q <= StIni;
                    end
                end
                default: begin
                    state_q <= StIni;
                end
            endcase
        end
    end

    assign bus.Bcd     = bcd_q;
    assign bus.Cnt     = cnt_q;
    assign bus.q_I     = state_q[0];
    assign bus.q_Shift = state_q[1];
    assign bus.q_Done  = state_q[2];

endmodule

// File: tb/tb_ee354_bin2bcd_seq.sv
module tb_ee354_bin2bcd_seq;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic Clk;
    logic Reset;

    int compared;
    int mismatched;

    ee354_bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    ee354_bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: decimal digits by plain arithmetic.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v)       % 10);
        r[7:4]  = 4'((v / 10)  % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    localparam logic [2:0] SI = 3'b100;
    localparam logic [2:0] SS = 3'b010;
    localparam logic [2:0] SD = 3'b001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp);
        check(tag, 32'({bus.q_I, bus.q_Shift, bus.q_Done}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Full conversion with SCEN tied high, then Ack back to idle.
    task automatic run_conv(input logic [7:0] b, input string tag);
        logic [11:0] exp;
        exp = ref_bcd(int'(b));
        bus.SCEN  = 1'b1;
        bus.Start = 1'b1;
        bus.Bin   = b;
        tick();
        bus.Start = 1'b0;
        check_state({tag, "_accept"}, SS);
        check({tag, "_bcd_clear"}, 32'(bus.Bcd), 32'h0);
        for (int i = 1; i <= int'(WIDTH); i++) begin
            tick();
            if (i < int'(WIDTH)) begin
                check_state({tag, "_shift"}, SS);
            end
        end
        check_state({tag, "_done"}, SD);
        check({tag, "_cnt"}, 32'(bus.Cnt), 32'(WIDTH));
        check({tag, "_bcd"}, 32'(bus.Bcd), 32'(exp));
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        check_state({tag, "_ack"}, SI);
        check({tag, "_bcd_kept"}, 32'(bus.Bcd), 32'(exp));
        check({tag, "_cnt_kept"}, 32'(bus.Cnt), 32'(WIDTH));
    endtask

    initial begin
        int en;
        logic [2:0] exp_st;
        compared   = 0;
        mismatched = 0;
        bus.SCEN   = 1'b0;
        bus.Start  = 1'b0;
        bus.Ack    = 1'b0;
        bus.Bin    = '0;
        Reset      = 1'b1;
        #1;
        check_state("reset_state", SI);
        check("reset_bcd", 32'(bus.Bcd), 32'h0);
        check("reset_cnt", 32'(bus.Cnt), 32'h0);
        tick();
        tick();
        Reset = 1'b0;

        run_conv(8'hFF, "ff");
        run_conv(8'h00, "zero");
        run_conv(8'h64, "x64");
        run_conv(8'h0A, "x0a");

        // Start presented only on a SCEN=0 cycle must not be accepted.
        bus.SCEN  = 1'b0;
        bus.Start = 1'b1;
        bus.Bin   = 8'd99;
        tick();
        check_state("start_noscen", SI);
        check("start_noscen_bcd", 32'(bus.Bcd), 32'(ref_bcd(10)));

        // SCEN 1-in-4; Start held until accepted.
        en = 0;
        for (int k = 0; k < 60 && en < 9; k++) begin
            bus.SCEN = (k % 4 == 0);
            tick();
            if (bus.SCEN) begin
                en++;
            end
            if (en >= 1) begin
                bus.Start = 1'b0;
            end
            exp_st = (en == 0) ? SI : (en <= 8) ? SS : SD;
            check_state("scen_state", exp_st);
            if (en >= 1) begin
                check("scen_cnt", 32'(bus.Cnt), 32'(en - 1));
            end
        end
        check("scen_budget", 32'(en), 32'd9);
        check("scen_bcd", 32'(bus.Bcd), 32'h099);

        // Tied Start/Ack pulse in DONE only returns to idle.
        bus.SCEN  = 1'b1;
        bus.Start = 1'b1;
        bus.Ack   = 1'b1;
        tick();
        check_state("tied_to_ini", SI);
        check("tied_bcd_kept", 32'(bus.Bcd), 32'h099);
        tick();
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        check_state("tied_restart", SS);
        check("tied_bcd_clear", 32'(bus.Bcd), 32'h0);
        for (int i = 0; i < int'(WIDTH); i++) tick();
        check_state("tied_done", SD);
        check("tied_bcd", 32'(bus.Bcd), 32'h099);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;

        // Async reset after 3 iterations of 0xC8.
        bus.Start = 1'b1;
        bus.Bin   = 8'hC8;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid_cnt3", 32'(bus.Cnt), 32'd3);
        #2;
        Reset = 1'b1;
        #1;
        check_state("async_rst_state", SI);
        check("async_rst_bcd", 32'(bus.Bcd), 32'h0);
        check("async_rst_cnt", 32'(bus.Cnt), 32'h0);
        tick();
        Reset = 1'b0;
        run_conv(8'hC8, "xc8");

        // Bin change mid-SHIFT has no effect.
        bus.Start = 1'b1;
        bus.Bin   = 8'h2A;
        tick();
        bus.Start = 1'b0;
        bus.Bin   = 8'h01;
        for (int i = 0; i < int'(WIDTH); i++) tick();
        check_state("binchg_done", SD);
        check("binchg_bcd", 32'(bus.Bcd), 32'h042);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;

        // Randomized conversions against the arithmetic reference.
        for (int r = 0; r < 24; r++) begin
            run_conv(8'($urandom_range(0, 255)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
